hazard_muldiv_ctrl: RTL and testbench
=====================================

Name: hazard_muldiv_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Generates StallF, StallD and FlushE; FlushE drives the ID/EX register's flush input.
- Generates decode-stage and execute-stage forwarding selects.
- Sequences the multi-cycle multiply/divide unit with a latency-counting FSM, and stalls decode while HI/LO are pending.

Parameters:
- MUL_LAT, 4, multiply latency in cycles from start to HI/LO write (min 2).
- DIV_LAT, 32, divide latency in cycles (min 2).
- CNT_W, 6, width of the latency counter (must hold max(MUL_LAT,DIV_LAT)-2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RsD, RtD  in  5  decode source registers.
- RsE, RtE  in  5  execute source registers.
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1  write enables per stage.
- MemToRegE, MemToRegM  in  1  load in stage.
- BranchD  in  1  branch resolving in decode.
- HiLoAccessD  in  1  decode instruction is mfhi/mflo/mthi/mtlo/mult/div.
- MulDivStartE  in  1  mult/div in execute (start pulse).
- MulDivOpE  in  1  0=mult, 1=div.
- StallF, StallD, FlushE  out  1  pipeline control.
- ForwardAD, ForwardBD  out  1  decode compare forwarding from M.
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 reg, 01 W result, 10 M ALU result.
- MulDivBusy  out  1  FSM in BUSY.
- MulDivDone  out  1  one-cycle HI/LO write strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE, counter to 0.
  - Outputs while in reset: MulDivBusy=0 and MulDivDone=0. All stall, flush and forward outputs are 0 whenever inputs are 0.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && WriteRegM!=0 && WriteRegM==RsE.
  - Else ForwardAE=01 if RegWriteW && WriteRegW!=0 && WriteRegW==RsE.
  - Else ForwardAE=00. M has priority over W.
  - ForwardBE uses the same rules with RtE.
  - ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM. ForwardBD uses the same rule with RtD.
- Stall conditions:
  - lwstall = MemToRegE && (RtE==RsD || RtE==RtD).
  - brstall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE∈{RsD,RtD}) || (MemToRegM && WriteRegM!=0 && WriteRegM∈{RsD,RtD})).
  - mdstall = HiLoAccessD && (state==BUSY || MulDivStartE).
  - StallF = StallD = FlushE = lwstall | brstall | mdstall.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on MulDivStartE, load cnt = (MulDivOpE ? DIV_LAT : MUL_LAT) - 2 and go to BUSY.
  - BUSY: if cnt==0 go to DONE, else cnt-1. MulDivBusy=1.
  - DONE: MulDivDone=1 for exactly one cycle, then IDLE. If MulDivStartE is asserted in DONE, load the counter and go directly to BUSY; Done is still asserted that cycle.
- Latency: start sampled at edge 0 gives MulDivDone high in cycle LAT.
  - Example: MUL_LAT=4 gives BUSY in cycles 1-3 and DONE in cycle 4.
- MulDivStartE while in BUSY cannot occur, because mdstall blocks a second mult/div. If it is asserted anyway it is ignored; the counter and state are unchanged.
- Reset asserted mid-operation aborts immediately to IDLE with no Done strobe.
- Simultaneous stall sources are OR-ed; there is no priority among them.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds output StallCount (32 bits), reset to 0.
  - Increments every cycle StallD=1.
  - Saturates at 32'hFFFFFFFF.
- When undefined:
  - Port and counter are absent.
  - Behaviour otherwise identical.

Test Plan:
- Load-use: MemToRegE=1, RtE=5, RsD=5 -> StallF=StallD=FlushE=1 in the same cycle. With RsD=6, RtD=7 -> all 0.
- Forward priority: RsE=3, RegWriteM=1, WriteRegM=3, RegWriteW=1, WriteRegW=3 -> ForwardAE=10. Drop RegWriteM -> 01. Set WriteRegM=WriteRegW=0 with RsE=0 -> 00.
- Branch hazard: BranchD=1, RsD=8, RegWriteE=1, WriteRegE=8 -> stall=1. Next cycle MemToRegM=0, RegWriteM=1, WriteRegM=8 -> stall=0, ForwardAD=1.
- Multiply: MulDivStartE=1, MulDivOpE=0 at cycle 0 (MUL_LAT=4) -> MulDivBusy=1 in cycles 1-3, MulDivDone=1 only in cycle 4. HiLoAccessD=1 held -> stall in cycles 0-3, released in cycle 4.
- Divide back-to-back: div start, then a second start asserted in the DONE cycle -> Done=1 in cycle 32, BUSY again in cycle 33, second Done in cycle 64.
- Reset mid-divide: reset=0 at cycle 10 of a divide -> Busy=0 asynchronously, no Done. After release, state is IDLE. With HAZARD_PERF_CNT_EN defined, StallCount=0.

Source files
------------

// File: rtl/hazard_muldiv_ctrl.sv
// hazard_muldiv_ctrl: hazard detection, forwarding selects and multiply/divide
// sequencing for the 5-stage pipeline.
// Optional feature: define HAZARD_PERF_CNT_EN to add the 32-bit saturating
// StallCount output, which counts cycles in which decode is stalled.
module hazard_muldiv_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemToRegE,
  input  logic        MemToRegM,
  input  logic        BranchD,
  input  logic        HiLoAccessD,
  input  logic        MulDivStartE,
  input  logic        MulDivOpE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MulDivBusy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] StallCount,
`endif
  output logic        MulDivDone
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;

  // Counter is loaded with LAT-2: one cycle is spent entering BUSY and one in DONE.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  mdState_t         state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] loadVal;
  logic             lwStall;
  logic             brStall;
  logic             mdStall;
  logic             stall;

  assign loadVal = MulDivOpE ? DIV_LOAD : MUL_LOAD;

  // ALU operand forwarding: the M stage result is newer than W, so it wins.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE))
      ForwardAE = 2'b10;
    else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE))
      ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE))
      ForwardBE = 2'b10;
    else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE))
      ForwardBE = 2'b01;
  end

  // Branch comparator in decode can only take the M stage ALU result.
  assign ForwardAD = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;

  // Stall sources are independent and simply OR-ed together.
  always_comb begin
    lwStall = MemToRegE && ((RtE == RsD) || (RtE == RtD));
    brStall = BranchD &&
              ((RegWriteE && (WriteRegE != 5'd0) &&
                ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
               (MemToRegM && (WriteRegM != 5'd0) &&
                ((WriteRegM == RsD) || (WriteRegM == RtD))));
    mdStall = HiLoAccessD && ((state == BUSY) || MulDivStartE);
    stall   = lwStall | brStall | mdStall;
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  // Multiply/divide latency FSM; Busy and Done are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      MulDivBusy <= 1'b0;
      MulDivDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MulDivDone <= 1'b0;
          if (MulDivStartE) begin
            cnt        <= loadVal;
            state      <= BUSY;
            MulDivBusy <= 1'b1;
          end
        end
        BUSY: begin
          // A start seen here is a second mult/div that decode should have held; ignore it.
          if (cnt == '0) begin
            state      <= DONE;
            MulDivBusy <= 1'b0;
            MulDivDone <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          MulDivDone <= 1'b0;
          if (MulDivStartE) begin
            cnt        <= loadVal;
            state      <= BUSY;
            MulDivBusy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          MulDivBusy <= 1'b0;
          MulDivDone <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating count of decode-stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      StallCount <= '0;
    else if (StallD && (StallCount != 32'hFFFF_FFFF))
      StallCount <= StallCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_muldiv_ctrl.sv
// Directed bench for hazard_muldiv_ctrl with a scoreboard of expected outputs.
module tb_hazard_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic        BranchD, HiLoAccessD, MulDivStartE, MulDivOpE;
  logic        StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MulDivBusy, MulDivDone;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [10:0] vec;
  } exp_t;
  exp_t sb[$];

  logic [10:0] outVec;
  assign outVec = {StallF, StallD, FlushE, ForwardAD, ForwardBD,
                   ForwardAE, ForwardBE, MulDivBusy, MulDivDone};

  hazard_muldiv_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
    .BranchD(BranchD), .HiLoAccessD(HiLoAccessD),
    .MulDivStartE(MulDivStartE), .MulDivOpE(MulDivOpE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulDivBusy(MulDivBusy),
`ifdef HAZARD_PERF_CNT_EN
    .StallCount(StallCount),
`endif
    .MulDivDone(MulDivDone)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [10:0] mk(input logic s, input logic fad, input logic fbd,
                                     input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic b, input logic d);
    return {s, s, s, fad, fbd, fae, fbe, b, d};
  endfunction

  task automatic push(input string tag, input logic [10:0] v);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic popCheck();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %b expected an entry", outVec);
    end else begin
      e = sb.pop_front();
      assert (outVec === e.vec) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", e.tag, outVec, e.vec);
      end
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs for the current cycle are already driven: compare at the negedge,
  // then move to just after the next rising edge.
  task automatic cyc(input string tag, input logic [10:0] v);
    push(tag, v);
    @(negedge clk);
    popCheck();
    @(posedge clk);
    #1;
  endtask

  task automatic zero();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemToRegE = 0; MemToRegM = 0; BranchD = 0;
    HiLoAccessD = 0; MulDivStartE = 0; MulDivOpE = 0;
  endtask

  initial begin
    reset = 1'b0;
    zero();
    #2;
    push("reset_state", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
    popCheck();
`ifdef HAZARD_PERF_CNT_EN
    check32("reset_stallcount", StallCount, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Load-use hazards
    MemToRegE = 1; RtE = 5; RsD = 5;
    cyc("loaduse_rs", mk(1, 0, 0, 2'b00, 2'b00, 0, 0));
    RsD = 0; RtD = 5;
    cyc("loaduse_rt", mk(1, 0, 0, 2'b00, 2'b00, 0, 0));
    RsD = 6; RtD = 7;
    cyc("loaduse_none", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // Forwarding priority
    zero();
    RsE = 3; RegWriteM = 1; WriteRegM = 3; RegWriteW = 1; WriteRegW = 3;
    cyc("fwdA_M", mk(0, 0, 0, 2'b10, 2'b00, 0, 0));
    RegWriteM = 0;
    cyc("fwdA_W", mk(0, 0, 0, 2'b01, 2'b00, 0, 0));
    RegWriteM = 1; RsE = 0; WriteRegM = 0; WriteRegW = 0;
    cyc("fwdA_r0", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
    RegWriteM = 0; RtE = 4; WriteRegW = 4;
    cyc("fwdB_W", mk(0, 0, 0, 2'b00, 2'b01, 0, 0));
    RegWriteM = 1; WriteRegM = 4;
    cyc("fwdB_M", mk(0, 0, 0, 2'b00, 2'b10, 0, 0));

    // Branch hazards
    zero();
    BranchD = 1; RsD = 8; RegWriteE = 1; WriteRegE = 8;
    cyc("br_exec", mk(1, 0, 0, 2'b00, 2'b00, 0, 0));
    RegWriteE = 0; WriteRegE = 0; MemToRegM = 0; RegWriteM = 1; WriteRegM = 8;
    cyc("br_fwdAD", mk(0, 1, 0, 2'b00, 2'b00, 0, 0));
    RsD = 0; RtD = 8; MemToRegM = 1;
    cyc("br_loadM", mk(1, 0, 1, 2'b00, 2'b00, 0, 0));
    zero();
    BranchD = 1; RegWriteE = 1; WriteRegE = 0;
    cyc("br_r0", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // Multiply, decode holding a HI/LO access; a stray start in BUSY is ignored
    zero();
    HiLoAccessD = 1; MulDivStartE = 1; MulDivOpE = 0;
    cyc("mul_c0", mk(1, 0, 0, 2'b00, 2'b00, 0, 0));
    for (int c = 1; c <= 5; c++) begin
      MulDivStartE = (c == 2);
      MulDivOpE    = (c == 2);
      cyc($sformatf("mul_c%0d", c),
          mk(c <= 3, 0, 0, 2'b00, 2'b00, c <= 3, c == 4));
    end

    // Divide with a second divide started in the DONE cycle
    zero();
    MulDivOpE = 1;
    for (int c = 0; c <= 65; c++) begin
      MulDivStartE = (c == 0) || (c == 32);
      cyc($sformatf("div_c%0d", c),
          mk(0, 0, 0, 2'b00, 2'b00,
             ((c >= 1) && (c <= 31)) || ((c >= 33) && (c <= 63)),
             (c == 32) || (c == 64)));
    end

    // Reset in the middle of a divide
    zero();
    MulDivOpE = 1;
    for (int c = 0; c <= 9; c++) begin
      MulDivStartE = (c == 0);
      cyc($sformatf("rdiv_c%0d", c), mk(0, 0, 0, 2'b00, 2'b00, c >= 1, 0));
    end
    MulDivStartE = 0;
    #2;
    reset = 1'b0;
    #1;
    push("rdiv_async", mk(0, 0, 0, 2'b00, 2'b00, 0, 0));
    popCheck();
`ifdef HAZARD_PERF_CNT_EN
    check32("rdiv_stallcount", StallCount, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 30; c++)
      cyc($sformatf("rdiv_idle%0d", c), mk(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // Simultaneous stall sources plus a fresh multiply after the abort
    MemToRegE = 1; RtE = 2; RsD = 2; HiLoAccessD = 1; MulDivStartE = 1; MulDivOpE = 0;
    cyc("multi_stall", mk(1, 0, 0, 2'b00, 2'b00, 0, 0));
    MemToRegE = 0; MulDivStartE = 0;
    cyc("post_abort_busy", mk(1, 0, 0, 2'b00, 2'b00, 1, 0));
`ifdef HAZARD_PERF_CNT_EN
    check32("stallcount_after2", StallCount, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
